// File: rtl/decoder_scan_seq.sv
// One-hot line driver: DECODE shows the selected line, SCAN walks a line.
// Ports: io_in = {dir,en,mode,sel[2:0],rst,clk}; io_out = registered lines.
// Build option: DECODER_SCAN_PINGPONG_EN makes SCAN bounce instead of wrap.
module decoder_scan_seq #(
  parameter int N_OUT    = 8,
  parameter int SCAN_DIV = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    BLANK,
    DECODE,
    SCAN
  } state_t;

  localparam logic [2:0] POS_MAX = 3'(N_OUT - 1);
  localparam logic [7:0] DIV_MAX = 8'(SCAN_DIV - 1);

  logic       clk;
  logic       rst;
  logic [2:0] sel;
  logic       mode;
  logic       en;
  logic       dir;
  logic       sel_ok;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign sel  = io_in[4:2];
  assign mode = io_in[5];
  assign en   = io_in[6];
  assign dir  = io_in[7];

  assign sel_ok = {1'b0, sel} < 4'(N_OUT);

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [7:0] div_q, div_d;
  logic [7:0] out_q, out_d;
`ifdef DECODER_SCAN_PINGPONG_EN
  // 0 = moving up, 1 = moving down
  logic       dn_q, dn_d;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    div_d   = div_q;
`ifdef DECODER_SCAN_PINGPONG_EN
    dn_d    = dn_q;
`endif
    unique case (state_q)
      BLANK: begin
        state_d = mode ? SCAN : DECODE;
        if (mode) begin
          pos_d = sel_ok ? sel : 3'd0;
          div_d = 8'd0;
`ifdef DECODER_SCAN_PINGPONG_EN
          dn_d  = 1'b0;
`endif
        end
      end
      DECODE: begin
        if (mode) state_d = BLANK;
      end
      SCAN: begin
        if (!mode) begin
          state_d = BLANK;
        end else if (en) begin
          if (div_q == DIV_MAX) begin
            div_d = 8'd0;
`ifdef DECODER_SCAN_PINGPONG_EN
            if (!dn_q) begin
              if (pos_q == POS_MAX) begin
                pos_d = pos_q - 3'd1;
                dn_d  = 1'b1;
              end else begin
                pos_d = pos_q + 3'd1;
              end
            end else begin
              if (pos_q == 3'd0) begin
                pos_d = 3'd1;
                dn_d  = 1'b0;
              end else begin
                pos_d = pos_q - 3'd1;
              end
            end
`else
            if (!dir) begin
              pos_d = (pos_q == POS_MAX) ? 3'd0 : pos_q + 3'd1;
            end else begin
              pos_d = (pos_q == 3'd0) ? POS_MAX : pos_q - 3'd1;
            end
`endif
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      default: state_d = BLANK;
    endcase
  end

`ifdef DECODER_SCAN_PINGPONG_EN
  logic unused_dir;
  assign unused_dir = dir;
`endif

  // Output follows the next state so the line is registered with the state.
  always_comb begin
    out_d = 8'd0;
    unique case (1'b1)
      (state_d == DECODE): out_d = (en && sel_ok) ? (8'd1 << sel) : 8'd0;
      (state_d == SCAN):   out_d = 8'd1 << pos_d;
      default:             out_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      pos_q   <= 3'd0;
      div_q   <= 8'd0;
      out_q   <= 8'd0;
`ifdef DECODER_SCAN_PINGPONG_EN
      dn_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      out_q   <= out_d;
`ifdef DECODER_SCAN_PINGPONG_EN
      dn_q    <= dn_d;
`endif
    end
  end

  assign io_out = out_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq over four parameter sets.
// Stimulus pushes expected lines; a monitor pops and compares per edge.
module tb_decoder_scan_seq;

  typedef struct {
    logic       care;
    logic [7:0] exp;
    string      nm;
  } ent_t;

  logic       clk = 1'b0;
  logic [6:0] ctl [4];
  logic [7:0] io_a, io_b, io_c, io_d;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [7:0] outs [4];
  ent_t       sbq [4][$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign io_a = {ctl[0], clk};
  assign io_b = {ctl[1], clk};
  assign io_c = {ctl[2], clk};
  assign io_d = {ctl[3], clk};
  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;
  assign outs[3] = out_d;

  decoder_scan_seq #(.N_OUT(8), .SCAN_DIV(1)) u_a (.io_in(io_a), .io_out(out_a));
  decoder_scan_seq #(.N_OUT(6), .SCAN_DIV(1)) u_b (.io_in(io_b), .io_out(out_b));
  decoder_scan_seq #(.N_OUT(8), .SCAN_DIV(3)) u_c (.io_in(io_c), .io_out(out_c));
  decoder_scan_seq #(.N_OUT(4), .SCAN_DIV(1)) u_d (.io_in(io_d), .io_out(out_d));

  // One edge on DUT d: drive inputs, expect the line after the edge.
  task automatic cyc(input int d, input logic rst, input logic [2:0] sel,
                     input logic mode, input logic en, input logic dir,
                     input logic [7:0] exp, input string nm);
    ent_t e;
    @(negedge clk);
    ctl[d] = {dir, en, mode, sel, rst};
    e.care = 1'b1;
    e.exp  = exp;
    e.nm   = nm;
    sbq[d].push_back(e);
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (sbq[i].size() > 0) begin
          e = sbq[i].pop_front();
          if (e.care) begin
            checks++;
            if (outs[i] !== e.exp) begin
              failures++;
              $display("FAIL %s dut%0d got=%02h want=%02h",
                       e.nm, i, outs[i], e.exp);
            end
            if (outs[i] !== 8'd0 && (outs[i] & (outs[i] - 8'd1)) !== 8'd0) begin
              failures++;
              $display("FAIL onehot dut%0d got=%02h want=onehot", i, outs[i]);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] pp_exp [5];
    logic       pp_dir [5];
    for (int i = 0; i < 4; i++) ctl[i] = 7'b0000001;
    @(posedge clk);

    // N_OUT=8, SCAN_DIV=1
    cyc(0, 1, 3'd5, 0, 1, 0, 8'h00, "a_rst");
    cyc(0, 0, 3'd5, 0, 1, 0, 8'h20, "a_dec5");
    cyc(0, 0, 3'd2, 0, 1, 0, 8'h04, "a_dec2");
    cyc(0, 0, 3'd7, 0, 1, 0, 8'h80, "a_dec7");
    cyc(0, 0, 3'd3, 0, 0, 0, 8'h00, "a_en0");
    cyc(0, 0, 3'd6, 1, 1, 0, 8'h00, "a_blank");
    cyc(0, 0, 3'd6, 1, 1, 0, 8'h40, "a_scan6");
    cyc(0, 0, 3'd6, 1, 1, 0, 8'h80, "a_scan7");
    cyc(0, 0, 3'd6, 1, 1, 0, 8'h01, "a_wrapup");
    cyc(0, 0, 3'd6, 1, 1, 0, 8'h02, "a_scan1");
    cyc(0, 0, 3'd6, 1, 1, 1, 8'h01, "a_down0");
    cyc(0, 0, 3'd6, 1, 1, 1, 8'h80, "a_wrapdn");
    cyc(0, 0, 3'd3, 1, 1, 0, 8'h01, "a_selign");
    cyc(0, 0, 3'd3, 1, 0, 1, 8'h01, "a_hold");
    cyc(0, 1, 3'd3, 1, 1, 0, 8'h00, "a_rstmid");
    cyc(0, 0, 3'd4, 1, 1, 0, 8'h10, "a_rescan");
    cyc(0, 0, 3'd1, 0, 1, 0, 8'h00, "a_todec");
    cyc(0, 0, 3'd1, 0, 1, 0, 8'h02, "a_dec1");

    // N_OUT=6, SCAN_DIV=1
    cyc(1, 1, 3'd7, 0, 1, 0, 8'h00, "b_rst");
    cyc(1, 0, 3'd7, 0, 1, 0, 8'h00, "b_sel7");
    cyc(1, 0, 3'd5, 0, 1, 0, 8'h20, "b_sel5");
    cyc(1, 0, 3'd6, 0, 1, 0, 8'h00, "b_sel6");
    cyc(1, 0, 3'd1, 0, 0, 0, 8'h00, "b_en0");
    cyc(1, 0, 3'd7, 1, 1, 0, 8'h00, "b_blank");
    cyc(1, 0, 3'd7, 1, 1, 0, 8'h01, "b_clamp0");
    cyc(1, 0, 3'd7, 1, 1, 1, 8'h20, "b_wrapdn");
    cyc(1, 0, 3'd7, 1, 1, 0, 8'h01, "b_wrapup");

    // N_OUT=8, SCAN_DIV=3
    cyc(2, 1, 3'd2, 1, 1, 0, 8'h00, "c_rst");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h04, "c_d0");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h04, "c_d1");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h04, "c_d2");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h08, "c_step3");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h08, "c_div1");
    for (int k = 0; k < 5; k++)
      cyc(2, 0, 3'd2, 1, 0, 1, 8'h08, "c_pause");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h08, "c_resume");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h10, "c_step4");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h10, "c_h1");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h10, "c_h2");
    cyc(2, 0, 3'd2, 1, 1, 0, 8'h20, "c_step5");

    // N_OUT=4, SCAN_DIV=1
`ifdef DECODER_SCAN_PINGPONG_EN
    pp_exp = '{8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    pp_dir = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    pp_exp = '{8'h08, 8'h01, 8'h02, 8'h04, 8'h08};
    pp_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    cyc(3, 1, 3'd2, 1, 1, 0, 8'h00, "d_rst");
    cyc(3, 0, 3'd2, 1, 1, 0, 8'h04, "d_start");
    for (int k = 0; k < 5; k++)
      cyc(3, 0, 3'd2, 1, 1, pp_dir[k], pp_exp[k], "d_seq");

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d left=%0d want=0", i, sbq[i].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 SHALL have parameter N_OUT, default 8, number of active one-hot output lines (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1, clock cycles per scan step (legal 1..255).
REQ-003 SHALL have port io_in[0]  input  1  clk, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port io_in[1]  input  1  rst, synchronous, active-high reset.
REQ-005 SHALL have port io_in[4:2]  input  3  sel, line index in DECODE; start index when SCAN is entered.
REQ-006 SHALL have port io_in[5]  input  1  mode, 0 = DECODE, 1 = SCAN.
REQ-007 SHALL have port io_in[6]  input  1  en, active-high enable.
REQ-008 SHALL have port io_in[7]  input  1  dir, scan direction, 0 = up, 1 = down.
REQ-009 SHALL have port io_out[7:0]  output  8  registered one-hot line outputs; bits N_OUT..7 tied 0.

Function
REQ-010 SHALL implement an FSM with states BLANK, DECODE, SCAN.
REQ-011 SHALL drive io_out = 0 for every cycle the FSM is in BLANK.
REQ-012 SHALL go from BLANK to DECODE if mode = 0, else to SCAN, after exactly one cycle in BLANK.
REQ-013 SHALL go from DECODE or SCAN to BLANK on any cycle where the sampled mode differs from the current state.
REQ-014 In DECODE, SHALL register io_out = (1 << sel) when en = 1 and sel < N_OUT, else 0; latency exactly 1 cycle.
REQ-015 On the BLANK-to-SCAN transition, SHALL load pos = sel (pos = 0 if sel >= N_OUT) and clear the divider to 0.
REQ-016 In SCAN, SHALL drive io_out = (1 << pos) regardless of en.
REQ-017 In SCAN with en = 1, SHALL increment the divider each cycle; at SCAN_DIV-1 it SHALL wrap to 0 and pos SHALL step one place.
REQ-018 In SCAN with en = 0, SHALL hold both pos and divider.
REQ-019 Step direction SHALL be dir as sampled on the step cycle; up wraps N_OUT-1 -> 0, down wraps 0 -> N_OUT-1.
REQ-020 io_out SHALL never have more than one bit set, in any state and any cycle.
REQ-021 sel changes while in SCAN SHALL have no effect until SCAN is re-entered.

Reset
REQ-022 rst = 1 SHALL force FSM = BLANK, pos = 0, divider = 0, io_out = 0 and internal bounce flag = up on the next edge; rst takes priority over all other inputs.
REQ-023 Reset asserted mid-scan SHALL abandon the scan; after rst falls, the block SHALL spend one BLANK cycle, then enter the state selected by mode.

Configuration
REQ-024 SHALL honour macro DECODER_SCAN_PINGPONG_EN.
REQ-025 With DECODER_SCAN_PINGPONG_EN defined, SCAN SHALL ignore dir and use an internal bounce flag that reverses at pos = N_OUT-1 (going up) and pos = 0 (going down); there is no wrap.
REQ-026 With DECODER_SCAN_PINGPONG_EN defined, entering SCAN SHALL set the bounce flag to up.
REQ-027 Without DECODER_SCAN_PINGPONG_EN, behaviour SHALL be exactly REQ-019, with no bounce-flag logic present.

Verification
REQ-028 Reset, mode = 0, en = 1, sel = 5 -> io_out = 0x00 for one BLANK cycle, then 0x20 from the following cycle; sel = 2 -> 0x04 one cycle later.
REQ-029 N_OUT = 6, DECODE, sel = 7 -> io_out = 0x00; en = 0 with sel = 1 -> 0x00.
REQ-030 N_OUT = 8, SCAN_DIV = 1, sel = 6, dir = 0, en = 1 -> sequence 0x40, 0x80, 0x01, 0x02; dir = 1 from 0x02 -> 0x01, 0x80.
REQ-031 SCAN_DIV = 3, SCAN, en = 1 -> each line held for 3 cycles; en = 0 for 5 cycles mid-step -> line and residual count preserved.
REQ-032 mode toggles 0 -> 1 while in DECODE -> one 0x00 cycle, then scan starts at the current sel; rst pulsed mid-scan -> io_out = 0x00 on the next edge.
REQ-033 PINGPONG_EN, N_OUT = 4, sel = 2 -> sequence 0x04, 0x08, 0x04, 0x02, 0x01, 0x02, independent of dir.
